// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb game control path and the countdown stage.
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DEFUSED,
    EXPLODED
  } state_t;

  localparam int WIRE_IDX_W = 2;

  // Both countdown digits read F once the 20 s countdown has underflowed.
  localparam logic [3:0] DIGIT_UNDERFLOW = 4'hF;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by registered level and change flags.
// rise = chg & lvl, fall = chg & ~lvl; change detection is blanked while the chain refills after reset.
module sync_edge #(
  parameter int               WIDTH       = 1,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] lvl,
  output logic [WIDTH-1:0] chg
);

  localparam int                 BLANK_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [BLANK_W-1:0] BLANK_LEN = BLANK_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]   sync_p0 [SYNC_STAGES];
  logic [WIDTH-1:0]   lvl_p1;
  logic [WIDTH-1:0]   chg_p1;
  logic [BLANK_W-1:0] blank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p0[i] <= RST_VAL;
      lvl_p1  <= RST_VAL;
      chg_p1  <= '0;
      blank_q <= BLANK_LEN;
    end else begin
      // p0: synchronizer chain
      sync_p0[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
      // p1: level and change flag, aligned so chg and the new level appear together
      lvl_p1 <= sync_p0[SYNC_STAGES-1];
      chg_p1 <= (blank_q == '0) ? (sync_p0[SYNC_STAGES-1] ^ lvl_p1) : '0;
      if (blank_q != '0) blank_q <= blank_q - BLANK_W'(1);
    end
  end

  assign lvl = lvl_p1;
  assign chg = chg_p1;

endmodule

// File: rtl/bomb_wire_ctrl.sv
// Game-control FSM: arms the countdown, tracks wire cuts against a secret order,
// and declares defusal or explosion (wrong cuts, simultaneous cuts, timeout).
module bomb_wire_ctrl
  import bomb_pkg::*;
#(
  parameter int         NUM_WIRES   = 4,
  parameter logic [7:0] CUT_ORDER   = 8'b01_10_00_11,
  parameter int         MAX_STRIKES = 2,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_arm,
  input  logic [NUM_WIRES-1:0] wire_n,
  input  logic [3:0]           cnt_ones,
  input  logic [3:0]           cnt_tens,
  output logic                 start,
  output logic                 success,
  output logic                 exploded,
  output logic [1:0]           strikes,
  output logic [1:0]           step,
  output logic                 wire_err
);

  logic [NUM_WIRES-1:0]  wire_lvl;
  logic [NUM_WIRES-1:0]  wire_chg;
  logic [NUM_WIRES-1:0]  cut_ev;
  logic                  btn_lvl;
  logic                  btn_chg;
  logic                  arm_press;

  state_t                state;
  state_t                state_nx;
  logic [1:0]            step_nx;
  logic [1:0]            strikes_nx;
  logic [1:0]            strikes_inc;
  logic                  err_nx;
  logic [WIRE_IDX_W-1:0] req_idx;
  logic                  timeout;
  logic                  multi_cut;
  logic                  any_cut;

  sync_edge #(
    .WIDTH       (NUM_WIRES),
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     ({NUM_WIRES{1'b1}})
  ) u_wire_sync (
    .clk (clk),
    .rst (rst),
    .din (wire_n),
    .lvl (wire_lvl),
    .chg (wire_chg)
  );

  sync_edge #(
    .WIDTH       (1),
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_btn_sync (
    .clk (clk),
    .rst (rst),
    .din (btn_arm),
    .lvl (btn_lvl),
    .chg (btn_chg)
  );

  assign arm_press   = btn_chg & btn_lvl;
  assign cut_ev      = wire_chg & ~wire_lvl;
  assign any_cut     = |cut_ev;
  // Clearing the lowest set bit leaves something only when two or more wires fell together.
  assign multi_cut   = (cut_ev & (cut_ev - NUM_WIRES'(1))) != '0;
  assign req_idx     = CUT_ORDER[{step, 1'b0} +: WIRE_IDX_W];
  assign timeout     = (cnt_tens == DIGIT_UNDERFLOW) && (cnt_ones == DIGIT_UNDERFLOW);
  assign strikes_inc = strikes + 2'd1;

  always_comb begin
    state_nx   = state;
    step_nx    = step;
    strikes_nx = strikes;
    err_nx     = 1'b0;
    unique case (state)
      IDLE: begin
        if (arm_press && (&wire_lvl)) begin
          state_nx   = ARMED;
          step_nx    = '0;
          strikes_nx = '0;
        end
      end
      ARMED: begin
        if (timeout || multi_cut) begin
          state_nx = EXPLODED;
        end else if (any_cut) begin
          if (cut_ev[req_idx]) begin
            if (step == 2'd3) state_nx = DEFUSED;
            else              step_nx  = step + 2'd1;
          end else begin
            err_nx     = 1'b1;
            strikes_nx = strikes_inc;
            if (strikes_inc == 2'(MAX_STRIKES)) state_nx = EXPLODED;
          end
        end
      end
      DEFUSED, EXPLODED: begin
        if (arm_press) begin
          state_nx   = IDLE;
          step_nx    = '0;
          strikes_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      step     <= '0;
      strikes  <= '0;
      wire_err <= 1'b0;
    end else begin
      state    <= state_nx;
      step     <= step_nx;
      strikes  <= strikes_nx;
      wire_err <= err_nx;
    end
  end

  assign start    = (state != IDLE);
  assign success  = (state == DEFUSED);
  assign exploded = (state == EXPLODED);

endmodule

// File: tb/tb_bomb_wire_ctrl.sv
// Self-checking bench for bomb_wire_ctrl: directed game scenarios plus random play
// compared against a rule-level game model.
module tb_bomb_wire_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_arm;
  logic [3:0] wire_n;
  logic [3:0] cnt_ones;
  logic [3:0] cnt_tens;
  logic       start;
  logic       success;
  logic       exploded;
  logic [1:0] strikes;
  logic [1:0] step;
  logic       wire_err;

  always #5 clk = ~clk;

  bomb_wire_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .btn_arm  (btn_arm),
    .wire_n   (wire_n),
    .cnt_ones (cnt_ones),
    .cnt_tens (cnt_tens),
    .start    (start),
    .success  (success),
    .exploded (exploded),
    .strikes  (strikes),
    .step     (step),
    .wire_err (wire_err)
  );

  localparam int G_IDLE  = 0;
  localparam int G_ARMED = 1;
  localparam int G_WON   = 2;
  localparam int G_BOOM  = 3;

  int order [4] = '{3, 0, 2, 1};
  int m_st   = G_IDLE;
  int m_step = 0;
  int m_strk = 0;
  int m_err  = 0;
  int total  = 0;
  int bad    = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Let an input change ripple through, counting wire_err pulses, then compare to the model.
  task automatic settle(input string tag);
    int errs;
    errs = 0;
    repeat (8) begin
      @(negedge clk);
      if (wire_err === 1'b1) errs++;
    end
    check_val({tag, ".start"},    int'(start),    int'(m_st != G_IDLE));
    check_val({tag, ".success"},  int'(success),  int'(m_st == G_WON));
    check_val({tag, ".exploded"}, int'(exploded), int'(m_st == G_BOOM));
    check_val({tag, ".strikes"},  int'(strikes),  m_strk);
    check_val({tag, ".step"},     int'(step),     m_step);
    check_val({tag, ".err"},      errs,           m_err);
    m_err = 0;
  endtask

  task automatic do_reset(input string tag, input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    check_val({tag, ".rst_start"},    int'(start),    0);
    check_val({tag, ".rst_success"},  int'(success),  0);
    check_val({tag, ".rst_exploded"}, int'(exploded), 0);
    check_val({tag, ".rst_strikes"},  int'(strikes),  0);
    check_val({tag, ".rst_step"},     int'(step),     0);
    check_val({tag, ".rst_err"},      int'(wire_err), 0);
    m_st = G_IDLE; m_step = 0; m_strk = 0; m_err = 0;
    settle({tag, ".post_rst"});
  endtask

  task automatic press(input string tag);
    btn_arm = 1'b1;
    if (m_st == G_IDLE) begin
      if (wire_n == 4'hF) begin
        m_st = G_ARMED; m_step = 0; m_strk = 0;
      end
    end else if (m_st != G_ARMED) begin
      m_st = G_IDLE; m_step = 0; m_strk = 0;
    end
    settle({tag, ".press"});
    btn_arm = 1'b0;
    settle({tag, ".release"});
  endtask

  task automatic cut(input string tag, input logic [3:0] mask);
    logic [3:0] fell;
    int idx;
    fell   = mask & wire_n;
    wire_n = wire_n & ~mask;
    if (m_st == G_ARMED && fell != 4'h0) begin
      if ($countones(fell) > 1) begin
        m_st = G_BOOM;
      end else begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (fell[i]) idx = i;
        if (idx == order[m_step]) begin
          if (m_step == 3) m_st = G_WON;
          else             m_step++;
        end else begin
          m_err = 1;
          m_strk++;
          if (m_strk == 2) m_st = G_BOOM;
        end
      end
    end
    settle(tag);
  endtask

  task automatic restore(input string tag);
    wire_n = 4'hF;
    settle(tag);
  endtask

  task automatic time_out(input string tag);
    cnt_tens = 4'hF;
    cnt_ones = 4'hF;
    if (m_st == G_ARMED) m_st = G_BOOM;
    settle(tag);
    cnt_tens = 4'($urandom_range(0, 1));
    cnt_ones = 4'($urandom_range(0, 9));
  endtask

  task automatic fresh_game(input string tag);
    if (m_st != G_IDLE) press({tag, ".to_idle"});
    restore({tag, ".restore"});
    press({tag, ".arm"});
  endtask

  initial begin
    logic [3:0] mask;
    int r, a, b;
    rst      = 1'b1;
    btn_arm  = 1'b1;
    wire_n   = 4'hF;
    cnt_tens = 4'h2;
    cnt_ones = 4'h0;

    // Button held high across reset release must not arm.
    do_reset("boot", 3);
    check_val("boot.no_arm", int'(start), 0);
    btn_arm = 1'b0;
    settle("boot.btn_low");

    // Correct order defuses.
    press("win.arm");
    cut("win.c3", 4'b1000);
    cut("win.c0", 4'b0001);
    cut("win.c2", 4'b0100);
    check_val("win.step3", int'(step), 3);
    cut("win.c1", 4'b0010);
    check_val("win.success", int'(success), 1);
    check_val("win.exploded", int'(exploded), 0);

    // Two wrong cuts explode.
    fresh_game("strike");
    cut("strike.w1", 4'b0010);
    check_val("strike.one", int'(strikes), 1);
    cut("strike.w0", 4'b0001);
    check_val("strike.boom", int'(exploded), 1);

    // Countdown underflow explodes; later correct cuts are ignored.
    fresh_game("tmo");
    time_out("tmo.ff");
    cut("tmo.c3", 4'b1000);
    check_val("tmo.no_success", int'(success), 0);

    // Simultaneous cut explodes without a strike.
    fresh_game("dual");
    cut("dual.c30", 4'b1001);
    check_val("dual.strikes", int'(strikes), 0);

    // Reset out of DEFUSED, then arming with a wire cut stays idle.
    fresh_game("rstwin");
    cut("rstwin.c3", 4'b1000);
    cut("rstwin.c0", 4'b0001);
    cut("rstwin.c2", 4'b0100);
    cut("rstwin.c1", 4'b0010);
    do_reset("rstwin", 1);
    restore("cutarm.restore");
    cut("cutarm.c2", 4'b0100);
    press("cutarm.press");
    check_val("cutarm.idle", int'(start), 0);

    // Random play.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 28) begin
        press("rnd.press");
      end else if (r < 62) begin
        mask = 4'(1 << $urandom_range(0, 3));
        cut("rnd.cut1", mask);
      end else if (r < 68) begin
        a = $urandom_range(0, 3);
        b = (a + $urandom_range(1, 3)) % 4;
        mask = 4'((1 << a) | (1 << b));
        cut("rnd.cut2", mask);
      end else if (r < 82) begin
        restore("rnd.restore");
      end else if (r < 90) begin
        time_out("rnd.timeout");
      end else begin
        do_reset("rnd", $urandom_range(1, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
